cia_access_sched: RTL and testbench
===================================

CIA_ACCESS_SCHED -- requirements
Module: cia_access_sched

Interface
REQ-001 SHALL have parameter DIV, default 8, meaning clk cycles per phi2 period; it SHALL be even and at least 4.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock.
REQ-003 SHALL have port res, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have ports cpu_req / host_req, input, 1 bit each: access request, held until the matching ack.
REQ-005 SHALL have ports cpu_rw / host_rw, input, 1 bit each: 1 = read, 0 = write.
REQ-006 SHALL have ports cpu_addr / host_addr, input, 4 bits each: CIA register select.
REQ-007 SHALL have ports cpu_wdata / host_wdata, input, 8 bits each: write data.
REQ-008 SHALL have ports cpu_ack / host_ack, output, 1 bit each: one-cycle completion pulse.
REQ-009 SHALL have ports cpu_rdata / host_rdata, output, 8 bits each: read data, valid from the ack cycle until the next ack to the same requester.
REQ-010 SHALL have port host_err, output, 1 bit: high with host_ack when the access was rejected.
REQ-011 SHALL have port host_icr_lock, input, 1 bit: when high, blocks host reads of register 0xD.
REQ-012 SHALL have ports phi2_p / phi2_n, output, 1 bit each: phase strobes to the CIA.
REQ-013 SHALL have ports cia_cs_n, cia_rw, cia_rs[3:0], cia_db_in[7:0], output: CIA bus signals.
REQ-014 SHALL have port cia_db_out, input, 8 bits: CIA read data.
REQ-015 SHALL have port busy, output, 1 bit: high in any non-IDLE state.

Function
REQ-016 SHALL run a free-running phase counter ph 0..DIV-1 that wraps to 0.
- phi2_p = 1 exactly when ph==0.
- phi2_n = 1 exactly when ph==DIV/2.
- Both strobes are registered outputs.
REQ-017 SHALL use states IDLE, ACTIVE, CAPTURE.
REQ-018 SHALL arbitrate only in IDLE on the cycle with ph==DIV-1, using the request lines sampled on that cycle.
REQ-019 SHALL arbitrate round-robin: if both request, grant the one not granted last; a single requester is granted immediately.
REQ-020 On grant, SHALL latch rw/addr/wdata onto cia_rw/cia_rs/cia_db_in and enter ACTIVE, with cia_cs_n=0 starting on the ph==0 cycle.
REQ-021 SHALL hold cia_cs_n=0 through the ph==DIV/2 cycle, then enter CAPTURE.
REQ-022 In CAPTURE (ph==DIV/2+1), SHALL:
- set cia_cs_n=1;
- for reads, copy cia_db_out into the granted requester's rdata;
- pulse the granted requester's ack;
- update the round-robin pointer;
- return to IDLE.
REQ-023 Access latency SHALL be DIV/2+2 cycles from the arbitration cycle to ack; exactly one CIA bus cycle occurs per grant.
REQ-024 A request dropped before its grant cycle SHALL be withdrawn with no ack; request changes after the grant SHALL be ignored.
REQ-025 A new grant SHALL occur at the earliest on the next ph==DIV-1 cycle, so back-to-back accesses are one phi2 period apart.
REQ-026 A host read of addr 0xD with host_icr_lock=1 at the grant cycle SHALL be rejected:
- no CIA cycle (cia_cs_n stays 1);
- host_ack and host_err pulse on the next cycle;
- host_rdata unchanged;
- pointer updated as for a normal grant.
REQ-027 CPU accesses to 0xD SHALL never be blocked.
REQ-028 Outside ACTIVE, cia_rw SHALL be 1 and cia_rs/cia_db_in SHALL hold their last values.

Reset
REQ-029 SHALL, while res=1 at a clk edge:
- ph=0, state IDLE;
- phi2_p=0, phi2_n=0, cia_cs_n=1, cia_rw=1, cia_rs=0, cia_db_in=0;
- both acks=0, both rdata=0, host_err=0, busy=0;
- round-robin pointer set to favour cpu.
REQ-030 A reset during ACTIVE or CAPTURE SHALL abort the access with no ack; the requester re-requests after reset.

Structure
REQ-031 A shared package SHALL hold the state enum, DIV default, and ICR_ADDR=4'hD constant.
REQ-032 The phase counter and strobes SHALL be sub-module cia_phase_gen (parameter DIV; outputs ph, phi2_p, phi2_n).

Verification
REQ-033 DIV=8, cpu read 0x4, CIA returns 0x5A: cs_n low for ph 0..4; cpu_ack at ph 5; cpu_rdata=0x5A.
REQ-034 cpu write 0x2 data 0xFF: cia_rw=0, cia_db_in=0xFF during ACTIVE; cpu_ack after 6 cycles; host_ack stays 0.
REQ-035 Both requesters held continuously: grants alternate cpu, host, cpu, host; acks are 8 cycles apart.
REQ-036 host read 0xD with lock=1: no cs_n low; host_ack=1 and host_err=1 one cycle later. Same access with lock=0: normal read, host_err=0.
REQ-037 res pulsed at ph 2 of ACTIVE: cs_n=1 and ph=0 next cycle; no ack; all outputs at reset values.
REQ-038 cpu_req dropped at ph 6 before arbitration: no grant, no ack, busy stays 0.

Source files
------------

// File: rtl/cia_access_sched_pkg.sv
// Shared types and constants for the CIA access scheduler.
package cia_access_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACTIVE  = 2'd1,
      S_CAPTURE = 2'd2
   } state_t;

   localparam int         DIV_DEFAULT = 8;
   localparam logic [3:0] ICR_ADDR    = 4'hD;

endpackage

// File: rtl/cia_phase_gen.sv
// Free-running phi2 phase counter with registered phase strobes.
module cia_phase_gen
   import cia_access_sched_pkg::*;
#(
   parameter int DIV = DIV_DEFAULT,
   parameter int PW  = $clog2(DIV)
) (
   input  logic          clk,
   input  logic          res,
   output logic [PW-1:0] ph,
   output logic          phi2_p,
   output logic          phi2_n
);

   localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);
   localparam logic [PW-1:0] PH_HALF = PW'(DIV / 2);

   logic [PW-1:0] ph_q, ph_d;
   logic          phi2_p_q, phi2_n_q;

   // Next phase, wrapping after DIV-1.
   always_comb begin
      ph_d = ph_q + PW'(1);
      if (ph_q == PH_LAST) ph_d = '0;
   end

   // Strobes are decoded from the next phase so they line up with ph.
   always_ff @(posedge clk) begin
      if (res) begin
         ph_q     <= '0;
         phi2_p_q <= 1'b0;
         phi2_n_q <= 1'b0;
      end else begin
         ph_q     <= ph_d;
         phi2_p_q <= (ph_d == '0);
         phi2_n_q <= (ph_d == PH_HALF);
      end
   end

   assign ph     = ph_q;
   assign phi2_p = phi2_p_q;
   assign phi2_n = phi2_n_q;

endmodule

// File: rtl/cia_access_sched.sv
// Two-requester (cpu/host) scheduler for a CIA register bus, one bus
// cycle per phi2 period, round-robin arbitration, host ICR read lock.
module cia_access_sched
   import cia_access_sched_pkg::*;
#(
   parameter int DIV = DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       res,
   input  logic       cpu_req,
   input  logic       cpu_rw,
   input  logic [3:0] cpu_addr,
   input  logic [7:0] cpu_wdata,
   output logic       cpu_ack,
   output logic [7:0] cpu_rdata,
   input  logic       host_req,
   input  logic       host_rw,
   input  logic [3:0] host_addr,
   input  logic [7:0] host_wdata,
   output logic       host_ack,
   output logic [7:0] host_rdata,
   output logic       host_err,
   input  logic       host_icr_lock,
   output logic       phi2_p,
   output logic       phi2_n,
   output logic       cia_cs_n,
   output logic       cia_rw,
   output logic [3:0] cia_rs,
   output logic [7:0] cia_db_in,
   input  logic [7:0] cia_db_out,
   output logic       busy
);

   localparam int            PW      = $clog2(DIV);
   localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);
   localparam logic [PW-1:0] PH_HALF = PW'(DIV / 2);

   logic [PW-1:0] ph;

   cia_phase_gen #(.DIV(DIV), .PW(PW)) u_phase (
      .clk    (clk),
      .res    (res),
      .ph     (ph),
      .phi2_p (phi2_p),
      .phi2_n (phi2_n)
   );

   state_t     state_q;
   logic       gnt_host_q;   // owner of the access in flight
   logic       ptr_host_q;   // 1 = host was granted last
   logic       cs_n_q, rw_q, busy_q;
   logic [3:0] rs_q;
   logic [7:0] db_in_q;
   logic       cpu_ack_q, host_ack_q, host_err_q;
   logic [7:0] cpu_rdata_q, host_rdata_q;

   logic       any_req_d, pick_host_d, reject_d;

   // Round-robin pick and the host ICR-lock rejection decision.
   always_comb begin
      any_req_d   = cpu_req | host_req;
      pick_host_d = host_req;
      if (cpu_req && host_req) pick_host_d = ~ptr_host_q;
      reject_d    = pick_host_d && host_rw && (host_addr == ICR_ADDR) && host_icr_lock;
   end

   // Access sequencer: arbitrate at the end of a phi2 period, drive one
   // CIA cycle, capture read data after the phi2_n strobe.
   always_ff @(posedge clk) begin
      if (res) begin
         state_q      <= S_IDLE;
         gnt_host_q   <= 1'b0;
         ptr_host_q   <= 1'b1;
         cs_n_q       <= 1'b1;
         rw_q         <= 1'b1;
         rs_q         <= '0;
         db_in_q      <= '0;
         busy_q       <= 1'b0;
         cpu_ack_q    <= 1'b0;
         host_ack_q   <= 1'b0;
         host_err_q   <= 1'b0;
         cpu_rdata_q  <= '0;
         host_rdata_q <= '0;
      end else begin
         cpu_ack_q  <= 1'b0;
         host_ack_q <= 1'b0;
         host_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (ph == PH_LAST && any_req_d) begin
                  gnt_host_q <= pick_host_d;
                  busy_q     <= 1'b1;
                  if (reject_d) begin
                     // Locked ICR read: answer immediately, no bus cycle.
                     host_ack_q <= 1'b1;
                     host_err_q <= 1'b1;
                     ptr_host_q <= 1'b1;
                     state_q    <= S_CAPTURE;
                  end else begin
                     cs_n_q  <= 1'b0;
                     rw_q    <= pick_host_d ? host_rw    : cpu_rw;
                     rs_q    <= pick_host_d ? host_addr  : cpu_addr;
                     db_in_q <= pick_host_d ? host_wdata : cpu_wdata;
                     state_q <= S_ACTIVE;
                  end
               end
            end
            S_ACTIVE: begin
               if (ph == PH_HALF) begin
                  cs_n_q     <= 1'b1;
                  rw_q       <= 1'b1;
                  ptr_host_q <= gnt_host_q;
                  if (gnt_host_q) begin
                     host_ack_q <= 1'b1;
                     if (rw_q) host_rdata_q <= cia_db_out;
                  end else begin
                     cpu_ack_q <= 1'b1;
                     if (rw_q) cpu_rdata_q <= cia_db_out;
                  end
                  state_q <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               cs_n_q  <= 1'b1;
               rw_q    <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cpu_ack    = cpu_ack_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign host_ack   = host_ack_q;
   assign host_rdata = host_rdata_q;
   assign host_err   = host_err_q;
   assign cia_cs_n   = cs_n_q;
   assign cia_rw     = rw_q;
   assign cia_rs     = rs_q;
   assign cia_db_in  = db_in_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_cia_access_sched.sv
// Self-checking bench for cia_access_sched with an ack scoreboard.
module tb_cia_access_sched;
   localparam int DIV = 8;

   logic       clk = 1'b0;
   logic       res;
   logic       cpu_req, cpu_rw, host_req, host_rw, host_icr_lock;
   logic [3:0] cpu_addr, host_addr;
   logic [7:0] cpu_wdata, host_wdata;
   logic       cpu_ack, host_ack, host_err, phi2_p, phi2_n, cia_cs_n, cia_rw, busy;
   logic [7:0] cpu_rdata, host_rdata, cia_db_in, cia_db_out;
   logic [3:0] cia_rs;

   // CIA model: fixed data, or data derived from the selected register.
   logic       db_map;
   logic [7:0] db_fixed;
   assign cia_db_out = db_map ? {cia_rs, ~cia_rs} : db_fixed;

   always #5 clk = ~clk;

   cia_access_sched #(.DIV(DIV)) dut (
      .clk(clk), .res(res),
      .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .host_req(host_req), .host_rw(host_rw), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_ack(host_ack), .host_rdata(host_rdata), .host_err(host_err),
      .host_icr_lock(host_icr_lock),
      .phi2_p(phi2_p), .phi2_n(phi2_n),
      .cia_cs_n(cia_cs_n), .cia_rw(cia_rw), .cia_rs(cia_rs), .cia_db_in(cia_db_in),
      .cia_db_out(cia_db_out), .busy(busy)
   );

   typedef struct {
      logic       host;
      logic [7:0] rdata;
      logic       err;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   ph_m = 0;
   bit   ph_ok = 0;
   int   ack_cyc[8];
   logic [7:0] m_cpu_rdata = 8'h00;
   logic [7:0] m_host_rdata = 8'h00;

   localparam logic [35:0] RESET_VEC = {1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 8'h00,
                                        1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
   logic [35:0] obs;
   assign obs = {phi2_p, phi2_n, cia_cs_n, cia_rw, cia_rs, cia_db_in,
                 cpu_ack, host_ack, cpu_rdata, host_rdata, host_err, busy};

   // Reference phase counter.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (res) begin
         ph_m  <= 0;
         ph_ok <= 0;
      end else begin
         ph_m  <= (ph_m == DIV - 1) ? 0 : ph_m + 1;
         ph_ok <= 1;
      end
   end

   // Strobe check every cycle, ack check against the scoreboard.
   always @(negedge clk) begin
      if (ph_ok && !res) begin
         vectors++;
         if (phi2_p !== (ph_m == 0) || phi2_n !== (ph_m == DIV / 2)) begin
            miscompares++;
            $display("FAIL strobes ph=%0d phi2_p=%b phi2_n=%b", ph_m, phi2_p, phi2_n);
         end
      end
      if (cpu_ack === 1'b1 || host_ack === 1'b1) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_ack cpu_ack=%b host_ack=%b expected none", cpu_ack, host_ack);
         end else begin
            e = sb.pop_front();
            if (host_ack !== e.host || cpu_ack !== !e.host ||
                (e.host ? host_rdata : cpu_rdata) !== e.rdata || host_err !== e.err) begin
               miscompares++;
               $display("FAIL ack_result got host_ack=%b cpu_ack=%b rdata=%h err=%b expected host=%b rdata=%h err=%b",
                        host_ack, cpu_ack, e.host ? host_rdata : cpu_rdata, host_err,
                        e.host, e.rdata, e.err);
            end
         end
      end
   end

   task automatic wait_ph(input int p);
      int n = 0;
      @(negedge clk);
      while (ph_m != p && n < 4 * DIV) begin
         @(negedge clk);
         n++;
      end
      if (ph_m != p) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_ph ph=%0d expected %0d", ph_m, p);
      end
   endtask

   task automatic collect_acks(input int n, input bit drop_each);
      int seen = 0;
      int budget = (n + 2) * DIV;
      while (seen < n && budget > 0) begin
         @(negedge clk);
         budget--;
         if (cpu_ack === 1'b1 || host_ack === 1'b1) begin
            ack_cyc[seen] = cyc;
            seen++;
            if (drop_each) begin
               if (cpu_ack) cpu_req = 1'b0;
               if (host_ack) host_req = 1'b0;
            end
         end
      end
      cpu_req = 1'b0;
      host_req = 1'b0;
      vectors++;
      if (seen != n) begin
         miscompares++;
         $display("FAIL collect_acks seen=%0d expected=%0d", seen, n);
      end
   endtask

   task automatic test_reset();
      res = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if (obs !== RESET_VEC) begin
         miscompares++;
         $display("FAIL reset_values got=%h expected=%h", obs, RESET_VEC);
      end
      res = 1'b0;
   endtask

   task automatic test_cpu_read();
      wait_ph(6);
      cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 4'h4;
      db_map = 1'b0; db_fixed = 8'h5A;
      sb.push_back('{1'b0, 8'h5A, 1'b0});
      m_cpu_rdata = 8'h5A;
      @(negedge clk);
      for (int k = 0; k <= DIV / 2; k++) begin
         @(negedge clk);
         vectors++;
         if (cia_cs_n !== 1'b0 || cia_rs !== 4'h4 || cia_rw !== 1'b1 || busy !== 1'b1 || cpu_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL cpu_read_active ph=%0d cs_n=%b rs=%h rw=%b busy=%b ack=%b expected 0 4 1 1 0",
                     ph_m, cia_cs_n, cia_rs, cia_rw, busy, cpu_ack);
         end
      end
      @(negedge clk);
      vectors++;
      if (cpu_ack !== 1'b1 || cia_cs_n !== 1'b1 || ph_m != 5) begin
         miscompares++;
         $display("FAIL cpu_read_ack ph=%0d ack=%b cs_n=%b expected ph 5 ack 1 cs_n 1", ph_m, cpu_ack, cia_cs_n);
      end
      cpu_req = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || cpu_rdata !== 8'h5A) begin
         miscompares++;
         $display("FAIL cpu_read_after busy=%b rdata=%h expected 0 5a", busy, cpu_rdata);
      end
   endtask

   task automatic test_cpu_write();
      bit bad = 0;
      wait_ph(6);
      cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 4'h2; cpu_wdata = 8'hFF;
      db_fixed = 8'h33;
      sb.push_back('{1'b0, m_cpu_rdata, 1'b0});
      @(negedge clk);
      for (int k = 0; k <= DIV / 2; k++) begin
         @(negedge clk);
         if (cia_cs_n !== 1'b0 || cia_rw !== 1'b0 || cia_db_in !== 8'hFF || cia_rs !== 4'h2 || host_ack !== 1'b0)
            bad = 1;
      end
      vectors++;
      if (bad) begin
         miscompares++;
         $display("FAIL cpu_write_active cs_n=%b rw=%b db_in=%h rs=%h expected 0 0 ff 2", cia_cs_n, cia_rw, cia_db_in, cia_rs);
      end
      @(negedge clk);
      vectors++;
      if (cpu_ack !== 1'b1 || host_ack !== 1'b0) begin
         miscompares++;
         $display("FAIL cpu_write_ack cpu_ack=%b host_ack=%b expected 1 0", cpu_ack, host_ack);
      end
      cpu_req = 1'b0;
      @(negedge clk);
      vectors++;
      if (cia_rw !== 1'b1 || cia_rs !== 4'h2 || cia_db_in !== 8'hFF || cpu_rdata !== 8'h5A) begin
         miscompares++;
         $display("FAIL cpu_write_hold rw=%b rs=%h db_in=%h rdata=%h expected 1 2 ff 5a", cia_rw, cia_rs, cia_db_in, cpu_rdata);
      end
   endtask

   task automatic test_back_to_back();
      wait_ph(6);
      db_map = 1'b1;
      host_icr_lock = 1'b0;
      cpu_req = 1'b1;  cpu_rw = 1'b1;  cpu_addr = 4'h1;
      host_req = 1'b1; host_rw = 1'b1; host_addr = 4'h3;
      // Cpu was granted last, so host goes first.
      sb.push_back('{1'b1, 8'h3C, 1'b0});
      sb.push_back('{1'b0, 8'h1E, 1'b0});
      sb.push_back('{1'b1, 8'h3C, 1'b0});
      sb.push_back('{1'b0, 8'h1E, 1'b0});
      m_cpu_rdata = 8'h1E;
      m_host_rdata = 8'h3C;
      collect_acks(4, 1'b0);
      for (int k = 1; k < 4; k++) begin
         vectors++;
         if (ack_cyc[k] - ack_cyc[k-1] != DIV) begin
            miscompares++;
            $display("FAIL b2b_spacing gap=%0d expected %0d", ack_cyc[k] - ack_cyc[k-1], DIV);
         end
      end
   endtask

   task automatic test_icr_lock();
      bit bad = 0;
      wait_ph(6);
      host_req = 1'b1; host_rw = 1'b1; host_addr = 4'hD; host_icr_lock = 1'b1;
      sb.push_back('{1'b1, m_host_rdata, 1'b1});
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (host_ack !== 1'b1 || host_err !== 1'b1 || cia_cs_n !== 1'b1) begin
         miscompares++;
         $display("FAIL icr_reject ack=%b err=%b cs_n=%b expected 1 1 1", host_ack, host_err, cia_cs_n);
      end
      host_req = 1'b0;
      repeat (DIV - 2) begin
         @(negedge clk);
         if (cia_cs_n !== 1'b1 || cia_rw !== 1'b1) bad = 1;
      end
      vectors++;
      if (bad) begin
         miscompares++;
         $display("FAIL icr_no_bus cs_n=%b rw=%b expected 1 1", cia_cs_n, cia_rw);
      end
      wait_ph(6);
      host_icr_lock = 1'b0;
      host_req = 1'b1;
      sb.push_back('{1'b1, 8'hD2, 1'b0});
      m_host_rdata = 8'hD2;
      collect_acks(1, 1'b1);
      wait_ph(6);
      host_icr_lock = 1'b1;
      cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 4'hD;
      sb.push_back('{1'b0, 8'hD2, 1'b0});
      m_cpu_rdata = 8'hD2;
      collect_acks(1, 1'b1);
      host_icr_lock = 1'b0;
   endtask

   task automatic test_reset_abort();
      bit bad = 0;
      wait_ph(6);
      cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 4'h7;
      repeat (3) @(negedge clk);
      @(negedge clk);
      res = 1'b1;
      @(negedge clk);
      res = 1'b0;
      cpu_req = 1'b0;
      m_cpu_rdata = 8'h00;
      m_host_rdata = 8'h00;
      vectors++;
      if (obs !== RESET_VEC) begin
         miscompares++;
         $display("FAIL reset_abort got=%h expected=%h", obs, RESET_VEC);
      end
      repeat (2 * DIV) begin
         @(negedge clk);
         if (cia_cs_n !== 1'b1 || cpu_ack !== 1'b0 || busy !== 1'b0) bad = 1;
      end
      vectors++;
      if (bad) begin
         miscompares++;
         $display("FAIL reset_abort_quiet cs_n=%b ack=%b busy=%b expected 1 0 0", cia_cs_n, cpu_ack, busy);
      end
      // After reset the pointer favours cpu.
      wait_ph(6);
      cpu_req = 1'b1;  cpu_rw = 1'b1;  cpu_addr = 4'h7;
      host_req = 1'b1; host_rw = 1'b1; host_addr = 4'h6;
      sb.push_back('{1'b0, 8'h78, 1'b0});
      sb.push_back('{1'b1, 8'h69, 1'b0});
      m_cpu_rdata = 8'h78;
      m_host_rdata = 8'h69;
      collect_acks(2, 1'b1);
   endtask

   task automatic test_withdraw();
      bit bad = 0;
      wait_ph(4);
      cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 4'h1;
      @(negedge clk);
      @(negedge clk);
      cpu_req = 1'b0;
      repeat (2 * DIV) begin
         @(negedge clk);
         if (busy !== 1'b0 || cia_cs_n !== 1'b1 || cpu_ack !== 1'b0) bad = 1;
      end
      vectors++;
      if (bad) begin
         miscompares++;
         $display("FAIL withdraw busy=%b cs_n=%b ack=%b expected 0 1 0", busy, cia_cs_n, cpu_ack);
      end
   endtask

   initial begin
      res = 1'b1;
      cpu_req = 1'b0;  cpu_rw = 1'b1;  cpu_addr = '0;  cpu_wdata = '0;
      host_req = 1'b0; host_rw = 1'b1; host_addr = '0; host_wdata = '0;
      host_icr_lock = 1'b0;
      db_map = 1'b0; db_fixed = 8'h00;
      test_reset();
      test_cpu_read();
      test_cpu_write();
      test_back_to_back();
      test_icr_lock();
      test_reset_abort();
      test_withdraw();
      repeat (4) @(negedge clk);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain pending=%0d expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule
